afifo_unpack_rd: RTL and testbench



---
 rtl/afifo_unpack_rd_if.sv | 29 ++
 rtl/afifo_unpack_rd.sv | 100 ++++++++++
 tb/tb_afifo_unpack_rd.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_unpack_rd_if.sv
// Bus bundle for the read-side unpacker: FIFO read port, byte stream and status.
interface afifo_unpack_rd_if #(
  parameter int dsize = 8,
  parameter int cntw  = 16
);
  logic                 en;
  logic                 rdready;
  logic                 rempty;
  logic [4*dsize-1:0]   rdata;
  logic                 rden;
  logic [dsize-1:0]     tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_last;
  logic                 busy;
  logic [cntw-1:0]      words_rd;

  // Unpacker side
  modport master (
    input  en, rdready, rempty, rdata, tx_ready,
    output rden, tx_data, tx_valid, tx_last, busy, words_rd
  );

  // Environment side (FIFO + byte sink)
  modport slave (
    output en, rdready, rempty, rdata, tx_ready,
    input  rden, tx_data, tx_valid, tx_last, busy, words_rd
  );
endinterface

// File: rtl/afifo_unpack_rd.sv
// Read-side unpacker: pops 32-bit words from the byte FIFO and streams
// them out MSB-first as dsize-bit bytes, with a one-word prefetch slot.
module afifo_unpack_rd #(
  parameter int dsize = 8,
  parameter int cntw  = 16
) (
  input  logic               rclk,
  input  logic               rrstn,
  afifo_unpack_rd_if.master  bus
);

  typedef enum logic {EMPTY, STREAM} state_t;

  state_t             state;
  logic [4*dsize-1:0] cur;
  logic [4*dsize-1:0] nxt;
  logic               nxt_v;
  logic [1:0]         idx;
  logic [cntw-1:0]    words_rd;
  logic [dsize-1:0]   byte_sel;
  logic               rden;
  logic               xfer;
  logic               last_xfer;

  // Pop only when the prefetch slot is free; gated by reset so nothing is
  // popped (and lost) while the block is held in reset.
  assign rden      = rrstn & bus.en & bus.rdready & ~bus.rempty & ~nxt_v;
  assign xfer      = (state == STREAM) & bus.tx_ready;
  assign last_xfer = xfer & (idx == 2'd3);

  // Select the current byte, oldest byte in the top lane.
  always_comb begin
    byte_sel = '0;
    case (idx)
      2'd0: byte_sel = cur[4*dsize-1:3*dsize];
      2'd1: byte_sel = cur[3*dsize-1:2*dsize];
      2'd2: byte_sel = cur[2*dsize-1:dsize];
      2'd3: byte_sel = cur[dsize-1:0];
      default: byte_sel = '0;
    endcase
  end

  // Word capture, byte sequencing and pop counting.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      state    <= EMPTY;
      cur      <= '0;
      nxt      <= '0;
      nxt_v    <= 1'b0;
      idx      <= '0;
      words_rd <= '0;
    end else begin
      if (rden) words_rd <= words_rd + cntw'(1);
      case (state)
        EMPTY: begin
          if (rden) begin
            cur   <= rdata_in();
            idx   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          // A pop while the current word is still busy lands in the prefetch
          // slot; when the last byte leaves this cycle it goes straight to cur.
          if (rden && !last_xfer) begin
            nxt   <= rdata_in();
            nxt_v <= 1'b1;
          end
          if (xfer) begin
            if (idx != 2'd3) begin
              idx <= idx + 2'd1;
            end else if (nxt_v) begin
              cur   <= nxt;
              nxt_v <= 1'b0;
              idx   <= '0;
            end else if (rden) begin
              cur <= rdata_in();
              idx <= '0;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  function automatic logic [4*dsize-1:0] rdata_in();
    return bus.rdata;
  endfunction

  assign bus.rden     = rden;
  assign bus.tx_valid = (state == STREAM);
  assign bus.tx_data  = byte_sel;
  assign bus.tx_last  = (state == STREAM) && (idx == 2'd3);
  assign bus.busy     = (state == STREAM) | nxt_v;
  assign bus.words_rd = words_rd;

endmodule

// File: tb/tb_afifo_unpack_rd.sv
// Bench for afifo_unpack_rd: FIFO model feeding words, scoreboard of
// expected bytes checked by an independent stream monitor.
module tb_afifo_unpack_rd;
  localparam int DSIZE = 8;
  localparam int CNTW  = 4;

  logic rclk;
  logic rrstn;

  afifo_unpack_rd_if #(.dsize(DSIZE), .cntw(CNTW)) bus ();

  afifo_unpack_rd #(.dsize(DSIZE), .cntw(CNTW)) dut (
    .rclk  (rclk),
    .rrstn (rrstn),
    .bus   (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // FIFO model
  logic [31:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign bus.rdready = (wr_ptr != rd_ptr);
  assign bus.rempty  = (wr_ptr == rd_ptr);
  assign bus.rdata   = bus.rden ? mem[rd_ptr % 64] : '1;

  always @(posedge rclk) if (bus.rden) rd_ptr <= rd_ptr + 1;

  // Scoreboard of {last, byte}
  logic [8:0] sb [$];
  int vectors = 0;
  int miscompares = 0;

  always @(negedge rclk) begin
    if (rrstn && bus.tx_valid && bus.tx_ready) begin
      logic [8:0] exp_v;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL tx_unexpected: got last=%0b data=%h, required no transfer",
                 bus.tx_last, bus.tx_data);
      end else begin
        exp_v = sb.pop_front();
        if ({bus.tx_last, bus.tx_data} !== exp_v) begin
          miscompares++;
          $display("FAIL tx_byte: got last=%0b data=%h, required last=%0b data=%h",
                   bus.tx_last, bus.tx_data, exp_v[8], exp_v[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  task automatic expect_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    sb.push_back({1'b0, b0});
    sb.push_back({1'b0, b1});
    sb.push_back({1'b0, b2});
    sb.push_back({1'b1, b3});
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(sb.size() == 0 && !bus.tx_valid) && n < budget) begin
      @(posedge rclk);
      #2;
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d bytes pending, required 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with data available and sink ready
    rrstn        = 1'b0;
    bus.en       = 1'b1;
    bus.tx_ready = 1'b1;
    push_word(32'hA1B2C3D4);
    push_word(32'h11223344);
    expect_bytes(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    expect_bytes(8'h11, 8'h22, 8'h33, 8'h44);
    repeat (3) tick();
    chk("rst_rden",     32'(bus.rden),     32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_last",  32'(bus.tx_last),  32'd0);
    chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_words_rd", 32'(bus.words_rd), 32'd0);

    @(negedge rclk);
    rrstn = 1'b1;
    #1;
    chk("first_rden",     32'(bus.rden),     32'd1);
    chk("first_no_valid", 32'(bus.tx_valid), 32'd0);
    tick();
    chk("first_valid",    32'(bus.tx_valid), 32'd1);
    chk("first_byte",     32'(bus.tx_data),  32'h0000_00A1);
    // Continuous stream: no bubble between the two words
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("stream_contig", 32'(bus.tx_valid), 32'd1);
    end
    tick();
    chk("stream_end_valid", 32'(bus.tx_valid), 32'd0);
    chk("stream_end_busy",  32'(bus.busy),     32'd0);
    chk("stream_words_rd",  32'(bus.words_rd), 32'd2);

    // Backpressure during the second byte
    push_word(32'h5A6B7C8D);
    push_word(32'h01020304);
    push_word(32'hF0E0D0C0);
    expect_bytes(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    expect_bytes(8'h01, 8'h02, 8'h03, 8'h04);
    expect_bytes(8'hF0, 8'hE0, 8'hD0, 8'hC0);
    tick();
    tick();
    chk("bp_prefetch_busy", 32'(bus.busy), 32'd1);
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data",  32'(bus.tx_data),  32'h0000_006B);
      chk("bp_hold_valid", 32'(bus.tx_valid), 32'd1);
      chk("bp_no_rden",    32'(bus.rden),     32'd0);
      chk("bp_words_rd",   32'(bus.words_rd), 32'd4);
    end
    bus.tx_ready = 1'b1;
    tick();
    chk("bp_resume", 32'(bus.tx_data), 32'h0000_007C);
    wait_idle(40);
    chk("bp_words_end", 32'(bus.words_rd), 32'd5);

    // Empty boundary
    push_word(32'hDEADBEEF);
    expect_bytes(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    wait_idle(20);
    chk("empty_valid", 32'(bus.tx_valid), 32'd0);
    chk("empty_busy",  32'(bus.busy),     32'd0);
    chk("empty_rden",  32'(bus.rden),     32'd0);
    chk("empty_words", 32'(bus.words_rd), 32'd6);
    push_word(32'h0F1E2D3C);
    expect_bytes(8'h0F, 8'h1E, 8'h2D, 8'h3C);
    #1;
    chk("refill_rden",     32'(bus.rden),     32'd1);
    chk("refill_no_valid", 32'(bus.tx_valid), 32'd0);
    tick();
    chk("refill_valid", 32'(bus.tx_valid), 32'd1);
    chk("refill_byte",  32'(bus.tx_data),  32'h0000_000F);
    wait_idle(20);
    chk("refill_words", 32'(bus.words_rd), 32'd7);

    // en dropped after two bytes with the prefetch slot full
    push_word(32'h10203040);
    push_word(32'h50607080);
    push_word(32'h90A0B0C0);
    expect_bytes(8'h10, 8'h20, 8'h30, 8'h40);
    expect_bytes(8'h50, 8'h60, 8'h70, 8'h80);
    tick();
    tick();
    tick();
    bus.en = 1'b0;
    chk("en_off_words", 32'(bus.words_rd), 32'd9);
    wait_idle(40);
    chk("en_off_drained_words", 32'(bus.words_rd), 32'd9);
    chk("en_off_rden",          32'(bus.rden),     32'd0);
    chk("en_off_busy",          32'(bus.busy),     32'd0);
    expect_bytes(8'h90, 8'hA0, 8'hB0, 8'hC0);
    bus.en = 1'b1;
    wait_idle(20);
    chk("en_on_words", 32'(bus.words_rd), 32'd10);

    // Counter wrap: 17 pops from a clean reset
    rrstn = 1'b0;
    tick();
    rrstn = 1'b1;
    chk("wrap_start", 32'(bus.words_rd), 32'd0);
    for (int i = 1; i <= 17; i++) begin
      logic [7:0] b;
      b = 8'(i);
      push_word({4{b}});
      expect_bytes(b, b, b, b);
    end
    wait_idle(150);
    chk("wrap_words", 32'(bus.words_rd), 32'd1);

    // Asynchronous reset mid-word
    push_word(32'hCAFEF00D);
    expect_bytes(8'hCA, 8'hFE, 8'hF0, 8'h0D);
    tick();
    tick();
    tick();
    push_word(32'h2468ACE0);
    push_word(32'h13579BDF);
    tick();
    #2;
    rrstn = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.tx_valid), 32'd0);
    chk("arst_last",  32'(bus.tx_last),  32'd0);
    chk("arst_busy",  32'(bus.busy),     32'd0);
    chk("arst_words", 32'(bus.words_rd), 32'd0);
    chk("arst_rden",  32'(bus.rden),     32'd0);
    sb.delete();
    expect_bytes(8'h13, 8'h57, 8'h9B, 8'hDF);
    @(negedge rclk);
    rrstn = 1'b1;
    wait_idle(20);
    chk("post_rst_words", 32'(bus.words_rd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
